// File: rtl/godai_trace_recorder_if.sv
// Trace drain channel between the recorder (master) and a downstream trace sink (slave).
// Handshake: rd_data_o is held stable while rd_valid_o=1; an entry transfers on a rising
// edge where rd_valid_o && rd_ready_i, and rd_valid_o never depends on rd_ready_i.
interface godai_trace_recorder_if #(
  parameter int ENTRY_W = 33
) ();
  logic               rd_valid_o;
  logic               rd_ready_i;
  logic [ENTRY_W-1:0] rd_data_o;

  modport master (
    output rd_valid_o,
    output rd_data_o,
    input  rd_ready_i
  );

  modport slave (
    input  rd_valid_o,
    input  rd_data_o,
    output rd_ready_i
  );
endinterface

// File: rtl/godai_trace_recorder.sv
// Pipeline-event trace recorder: timestamps masked core strobes and buffers them in a FIFO,
// marking timestamp wrap in-stream and counting entries dropped on overflow.
module godai_trace_recorder #(
  parameter int NUM_CHANNELS = 9,
  parameter int TS_WIDTH     = 24,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic                      mode_i,
  input  logic                      clear_i,
  input  logic [NUM_CHANNELS-1:0]   chan_mask_i,
  input  logic [NUM_CHANNELS-1:0]   event_i,
  godai_trace_recorder_if.master    rd_if,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o,
  output logic [15:0]               drop_count_o
);
  localparam int ENTRY_W = TS_WIDTH + NUM_CHANNELS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  logic [NUM_CHANNELS-1:0] prev_q, prev_d;
  logic [TS_WIDTH-1:0]     ts_q, ts_d;
  logic                    mark_q, mark_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             drop_q, drop_d;
  logic [ENTRY_W-1:0]      mem_q [DEPTH];

  logic [NUM_CHANNELS-1:0] masked, hit;
  logic                    ev_push, push, rd_valid, pop, full, wr_en, drop, mem_we;
  logic [ENTRY_W-1:0]      push_data;

  always_comb begin
    masked    = event_i & chan_mask_i;
    hit       = mode_i ? (masked & ~prev_q) : masked;
    ev_push   = enable_i && (|hit);
    // An event entry stamped ts=0 already implies the wrap, so it absorbs a pending marker.
    push      = ev_push || mark_q;
    push_data = ev_push ? {ts_q, hit} : '0;
    rd_valid  = (count_q != '0);
    pop       = rd_valid && rd_if.rd_ready_i;
    full      = (count_q == LVL_W'(DEPTH));
    wr_en     = push && (!full || pop);
    drop      = push && full && !pop;
    mem_we    = wr_en && !clear_i;

    prev_d   = masked;
    ts_d     = enable_i ? ts_q + TS_WIDTH'(1) : ts_q;
    mark_d   = enable_i && (ts_q == '1);
    rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + LVL_W'(1);
    else if (!wr_en && pop) count_d = count_q - LVL_W'(1);
    ovf_d    = ovf_q || drop;
    drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

    // Flush wins over push/pop; prev keeps tracking so edge detection stays continuous.
    if (clear_i) begin
      ts_d     = '0;
      mark_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= '0;
      ts_q     <= '0;
      mark_q   <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      prev_q   <= prev_d;
      ts_q     <= ts_d;
      mark_q   <= mark_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign rd_if.rd_valid_o = rd_valid;
  assign rd_if.rd_data_o  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level_o          = count_q;
  assign overflow_o       = ovf_q;
  assign drop_count_o     = drop_q;
endmodule

// File: tb/tb_godai_trace_recorder.sv
// Directed bench for godai_trace_recorder (9 channels, 8-bit timestamp, 16-deep FIFO)
// with an expected-entry queue compared on every accepted pop.
module tb_godai_trace_recorder;
  localparam int NCH = 9;
  localparam int TSW = 8;
  localparam int DEP = 16;
  localparam int EW  = TSW + NCH;

  logic           clk = 1'b0;
  logic           rst, enable_i, mode_i, clear_i;
  logic [NCH-1:0] chan_mask_i, event_i;
  logic [4:0]     level_o;
  logic           overflow_o;
  logic [15:0]    drop_count_o;

  godai_trace_recorder_if #(.ENTRY_W(EW)) rd_if ();

  godai_trace_recorder #(.NUM_CHANNELS(NCH), .TS_WIDTH(TSW), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .clear_i      (clear_i),
    .chan_mask_i  (chan_mask_i),
    .event_i      (event_i),
    .rd_if        (rd_if),
    .level_o      (level_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int            total_cnt = 0;
  int            bad_cnt   = 0;
  int            tb_ts     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      bad_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input int ts, input logic [NCH-1:0] h);
    logic [TSW-1:0] t;
    t = TSW'(ts);
    return {t, h};
  endfunction

  // One clock: score any pop accepted at this edge, advance the timestamp model, settle.
  task automatic tick();
    logic [EW-1:0] head;
    if (rd_if.rd_ready_i && rd_if.rd_valid_o) begin
      if (exp_q.size() == 0) check("sb_unexpected_pop", 32'(rd_if.rd_data_o), 32'h1_FFFF_FFF);
      else begin
        head = exp_q.pop_front();
        check("sb_data", 32'(rd_if.rd_data_o), 32'(head));
      end
    end
    @(posedge clk);
    if (rst || clear_i) tb_ts = 0;
    else if (enable_i)  tb_ts = (tb_ts + 1) % 256;
    #1;
  endtask

  task automatic drain();
    enable_i = 1'b0;
    rd_if.rd_ready_i = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    rd_if.rd_ready_i = 1'b0;
    check("drain_valid", 32'(rd_if.rd_valid_o), 32'd0);
  endtask

  task automatic run_to_ts(input int target);
    for (int i = 0; i < 300 && tb_ts != target; i++) tick();
    check("ts_reach", 32'(tb_ts), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(rd_if.rd_valid_o), 32'd0);
    check({tag, "_level"}, 32'(level_o), 32'd0);
    check({tag, "_ovf"},   32'(overflow_o), 32'd0);
    check({tag, "_drop"},  32'(drop_count_o), 32'd0);
    check({tag, "_data"},  32'(rd_if.rd_data_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b0; mode_i = 1'b0; clear_i = 1'b0;
    chan_mask_i = 9'h1FF; event_i = '0; rd_if.rd_ready_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Level mode: 003 held three cycles from ts=5.
    enable_i = 1'b1;
    run_to_ts(5);
    event_i = 9'h003;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ent(tb_ts, 9'h003));
      tick();
      if (i == 0) begin
        check("lvl_first_valid", 32'(rd_if.rd_valid_o), 32'd1);
        check("lvl_first_data", 32'(rd_if.rd_data_o), 32'(ent(5, 9'h003)));
      end
    end
    event_i = '0; enable_i = 1'b0;
    check("lvl_level", 32'(level_o), 32'd3);
    drain();

    // Edge mode: one entry per rising edge; masked channel 8 toggles silently.
    mode_i = 1'b1; chan_mask_i = 9'h0FF; enable_i = 1'b1;
    exp_q.push_back(ent(tb_ts, 9'h001));
    for (int i = 0; i < 4; i++) begin
      event_i = {~event_i[8], 8'h01};
      tick();
    end
    event_i = '0;
    for (int i = 0; i < 300 && tb_ts != 20; i++) begin
      event_i[8] = ~event_i[8];
      tick();
    end
    event_i = 9'h001;
    exp_q.push_back(ent(20, 9'h001));
    tick();
    event_i = 9'h100; tick();
    event_i = '0; enable_i = 1'b0;
    check("edge_level", 32'(level_o), 32'd2);
    drain();

    // Overflow: 20 level hits into a 16-deep FIFO with the sink stalled.
    mode_i = 1'b0; chan_mask_i = 9'h1FF; enable_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      event_i = 9'(i + 1);
      if (i < 16) exp_q.push_back(ent(tb_ts, 9'(i + 1)));
      tick();
    end
    check("ovf_level", 32'(level_o), 32'd16);
    check("ovf_drop", 32'(drop_count_o), 32'd4);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_head", 32'(rd_if.rd_data_o), 32'(ent(tb_ts - 20, 9'h001)));
    event_i = 9'h055; rd_if.rd_ready_i = 1'b1;
    exp_q.push_back(ent(tb_ts, 9'h055));
    tick();
    event_i = '0; rd_if.rd_ready_i = 1'b0;
    check("full_pop_level", 32'(level_o), 32'd16);
    check("full_pop_drop", 32'(drop_count_o), 32'd4);
    drain();

    // Timestamp wrap with no events: single marker entry.
    enable_i = 1'b1;
    run_to_ts(255);
    tick();
    exp_q.push_back('0);
    tick();
    check("wrap_valid", 32'(rd_if.rd_valid_o), 32'd1);
    tick(); tick();
    check("wrap_level", 32'(level_o), 32'd1);
    drain();

    // Wrap again with a hit at ts=0: only the event entry.
    enable_i = 1'b1;
    run_to_ts(255);
    tick();
    event_i = 9'h004;
    exp_q.push_back(ent(0, 9'h004));
    tick();
    event_i = '0;
    tick(); tick();
    check("wrap_hit_level", 32'(level_o), 32'd1);
    drain();

    // Clear with 7 queued, concurrent hit and pop.
    enable_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      event_i = 9'(i + 1);
      exp_q.push_back(ent(tb_ts, 9'(i + 1)));
      tick();
    end
    event_i = '0;
    check("pre_clr_level", 32'(level_o), 32'd7);
    check("pre_clr_ovf", 32'(overflow_o), 32'd1);
    clear_i = 1'b1; event_i = 9'h1FF; rd_if.rd_ready_i = 1'b1;
    tick();
    clear_i = 1'b0; event_i = '0; rd_if.rd_ready_i = 1'b0;
    exp_q.delete();
    check("clr_level", 32'(level_o), 32'd0);
    check("clr_valid", 32'(rd_if.rd_valid_o), 32'd0);
    check("clr_ovf", 32'(overflow_o), 32'd0);
    check("clr_drop", 32'(drop_count_o), 32'd0);
    event_i = 9'h001;
    exp_q.push_back(ent(0, 9'h001));
    tick();
    event_i = '0;
    drain();

    // Reset mid-stream with the sink toggling ready.
    enable_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      event_i = 9'(i + 1);
      rd_if.rd_ready_i = (i % 2) == 1;
      exp_q.push_back(ent(tb_ts, 9'(i + 1)));
      tick();
    end
    rst = 1'b1; event_i = 9'h0F0; rd_if.rd_ready_i = 1'b1;
    tick();
    rst = 1'b0; event_i = '0; rd_if.rd_ready_i = 1'b0;
    exp_q.delete();
    check_reset_outputs("midrst");
    event_i = 9'h002;
    exp_q.push_back(ent(0, 9'h002));
    tick();
    event_i = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
